// File: rtl/spi_slave_gen_if.sv
// Bus bundle between the SPI slave front-end and the memory-side wrapper.
// The slave modport is the DUT view; master is the driver/memory view.
interface spi_slave_gen_if #(
  parameter int DATA_W = 8
) ();
  localparam int RX_W = DATA_W + 2;

  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [RX_W-1:0]   rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              busy;
  logic              frame_err;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, busy, frame_err
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, busy, frame_err
  );
endinterface

// File: rtl/spi_slave_gen.sv
// SPI slave front-end clocked by SCK: deserialises rw + {cmd, payload},
// strobes the word to the memory side and streams read data back on MISO.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | SS_n high, waiting for a frame
// CHK_CMD   | sampling the rw bit
// WRITE     | shifting in a write word
// READ_ADD  | shifting in a read-address word, sets rd_pend on completion
// READ_DATA | shifting in the read-data request word
// TX_WAIT   | waiting for tx_valid from the memory side
// TX        | shifting the latched read data out on MISO, MSB first
// DONE      | frame complete, extra bits ignored until SS_n rises
module spi_slave_gen #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_slave_gen_if.slave bus
);
  localparam int RX_W = DATA_W + 2;

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RX_W-2:0]   shift_q, shift_d;
  logic [RX_W-1:0]   rx_data_q, rx_data_d;
  logic [DATA_W-2:0] tx_shift_q, tx_shift_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              miso_q, miso_d;
  logic              rd_pend_q, rd_pend_d;

  logic in_frame;
  logic abort;
  logic rx_phase;
  logic rx_last;
  logic tx_last;

  // SS_n rising anywhere before DONE truncates the frame, even on the last bit.
  assign in_frame = (state_q == CHK_CMD) || (state_q == WRITE) ||
                    (state_q == READ_ADD) || (state_q == READ_DATA) ||
                    (state_q == TX_WAIT) || (state_q == TX);
  assign abort    = in_frame && bus.SS_n;
  assign rx_phase = (state_q == WRITE) || (state_q == READ_ADD) ||
                    (state_q == READ_DATA);
  assign rx_last  = rx_phase && (cnt_q == CNT_W'(RX_W - 1));
  assign tx_last  = (state_q == TX) && (cnt_q == CNT_W'(DATA_W));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      tx_shift_q  <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      tx_shift_q  <= tx_shift_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (!bus.SS_n) state_d = CHK_CMD;
        CHK_CMD: begin
          if (!bus.MOSI)     state_d = WRITE;
          else if (rd_pend_q) state_d = READ_DATA;
          else               state_d = READ_ADD;
        end
        WRITE:     if (rx_last) state_d = DONE;
        READ_ADD:  if (rx_last) state_d = DONE;
        READ_DATA: if (rx_last) state_d = TX_WAIT;
        TX_WAIT:   if (bus.tx_valid) state_d = TX;
        TX:        if (tx_last) state_d = DONE;
        DONE:      if (bus.SS_n) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    tx_shift_d  = tx_shift_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    miso_d      = 1'b0;
    rd_pend_d   = rd_pend_q;
    if (abort) begin
      // rd_pend is kept so an aborted read-data frame can be retried.
      frame_err_d = 1'b1;
      cnt_d       = '0;
    end else begin
      case (state_q)
        WRITE, READ_ADD, READ_DATA: begin
          shift_d = {shift_q[RX_W-3:0], bus.MOSI};
          cnt_d   = cnt_q + CNT_W'(1);
          if (rx_last) begin
            rx_data_d  = {shift_q, bus.MOSI};
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            if (state_q == READ_ADD) rd_pend_d = 1'b1;
          end
        end
        TX_WAIT: begin
          if (bus.tx_valid) begin
            miso_d     = bus.tx_data[DATA_W-1];
            tx_shift_d = bus.tx_data[DATA_W-2:0];
            cnt_d      = CNT_W'(1);
          end
        end
        TX: begin
          // cnt_q counts bits already presented; bit 0 gets a full cycle.
          if (tx_last) begin
            rd_pend_d = 1'b0;
            cnt_d     = '0;
          end else begin
            miso_d     = tx_shift_q[DATA_W-2];
            tx_shift_d = tx_shift_q << 1;
            cnt_d      = cnt_q + CNT_W'(1);
          end
        end
        DONE:    if (bus.SS_n) cnt_d = '0;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.MISO      = miso_q;
    bus.rx_data   = rx_data_q;
    bus.rx_valid  = rx_valid_q;
    bus.frame_err = frame_err_q;
  end
endmodule

// File: tb/tb_spi_slave_gen.sv
// Self-checking bench for spi_slave_gen at DATA_W=8 and DATA_W=16.
// Expected rx words and MISO bits are queued as stimulus is driven.
module tb_spi_slave_gen;
  logic clk;
  logic rst_n;

  spi_slave_gen_if #(.DATA_W(8))  bus8 ();
  spi_slave_gen_if #(.DATA_W(16)) bus16 ();

  spi_slave_gen #(.DATA_W(8), .CNT_W(5)) u_dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8)
  );

  spi_slave_gen #(.DATA_W(16), .CNT_W(5)) u_dut16 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          sel16    = 1'b0;
  int          obs_cyc, obs_nvalid, obs_vcyc, obs_nerr, obs_miso_hi;
  logic [17:0] obs_rx;
  logic [17:0] exp_rx_q[$];
  logic        exp_bit_q[$];
  logic [17:0] last_rx8;

  task automatic drv(input logic ss, input logic mosi);
    if (sel16) begin bus16.SS_n = ss; bus16.MOSI = mosi; end
    else begin bus8.SS_n = ss; bus8.MOSI = mosi; end
  endtask

  task automatic drv_tx(input logic v, input logic [15:0] d);
    bus16.tx_valid = sel16 ? v : 1'b0;
    bus16.tx_data  = d;
    bus8.tx_valid  = sel16 ? 1'b0 : v;
    bus8.tx_data   = d[7:0];
  endtask

  function automatic logic get_miso();  return sel16 ? bus16.MISO : bus8.MISO; endfunction
  function automatic logic get_busy();  return sel16 ? bus16.busy : bus8.busy; endfunction
  function automatic logic get_ferr();  return sel16 ? bus16.frame_err : bus8.frame_err; endfunction
  function automatic logic get_rxv();   return sel16 ? bus16.rx_valid : bus8.rx_valid; endfunction
  function automatic logic [17:0] get_rx(); return sel16 ? bus16.rx_data : {8'd0, bus8.rx_data}; endfunction

  task automatic clear_obs();
    obs_cyc = -1; obs_nvalid = 0; obs_vcyc = -1; obs_nerr = 0; obs_miso_hi = 0; obs_rx = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    obs_cyc++;
    if (get_rxv()) begin obs_nvalid++; obs_vcyc = obs_cyc; obs_rx = get_rx(); end
    if (get_ferr()) obs_nerr++;
    if (get_miso()) obs_miso_hi++;
  endtask

  // Drives SS_n low, the rw bit and nbits of word; leaves SS_n low.
  task automatic frame(input logic rw, input logic [17:0] word, input int rxw, input int nbits);
    logic [17:0] exp;
    clear_obs();
    drv(1'b0, 1'b0); tick();
    drv(1'b0, rw);   tick();
    for (int i = 0; i < nbits; i++) begin
      drv(1'b0, word[rxw-1-i]);
      tick();
    end
    if (nbits == rxw) begin
      n_checks++;
      if (obs_nvalid != 1 || obs_vcyc != rxw + 1) begin
        n_fail++; $display("FAIL rx_latency: got %0d pulses at cycle %0d want 1 at cycle %0d", obs_nvalid, obs_vcyc, rxw + 1);
      end
      exp = 'x;
      if (exp_rx_q.size() > 0) exp = exp_rx_q.pop_front();
      n_checks++;
      if (obs_rx !== exp) begin n_fail++; $display("FAIL rx_data: got %h want %h", obs_rx, exp); end
    end
  endtask

  // Closes a completed frame; tx_valid is offered while in DONE to expose a wrong state.
  task automatic end_frame();
    drv_tx(1'b1, 16'hFFFF); drv(1'b0, 1'b1);
    tick(); tick();
    drv_tx(1'b0, 16'h0000); drv(1'b1, 1'b0);
    tick(); tick();
  endtask

  task automatic tx_stream(input int dw, input logic [15:0] d);
    logic eb;
    drv_tx(1'b0, 16'h0000);
    repeat (3) tick();
    n_checks++;
    if (obs_miso_hi != 0 || get_busy() !== 1'b1) begin
      n_fail++; $display("FAIL tx_wait: got miso_hi=%0d busy=%b want 0 and 1", obs_miso_hi, get_busy());
    end
    for (int i = 0; i < dw; i++) exp_bit_q.push_back(d[dw-1-i]);
    drv_tx(1'b1, d);
    tick();
    drv_tx(1'b0, 16'h0000);
    for (int i = 0; i < dw; i++) begin
      if (i > 0) tick();
      eb = exp_bit_q.pop_front();
      n_checks++;
      if (get_miso() !== eb) begin n_fail++; $display("FAIL tx_bit%0d: got %b want %b", dw - 1 - i, get_miso(), eb); end
    end
    tick();
    n_checks++;
    if (get_miso() !== 1'b0 || get_busy() !== 1'b1) begin
      n_fail++; $display("FAIL tx_done: got miso=%b busy=%b want 0 and 1", get_miso(), get_busy());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus8.MISO, bus8.rx_valid, bus8.frame_err, bus8.busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl8: got %b want 0000", {bus8.MISO, bus8.rx_valid, bus8.frame_err, bus8.busy});
    end
    n_checks++;
    if (bus8.rx_data !== 10'h000 || bus16.rx_data !== 18'h00000 || bus16.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h busy16=%b want 0", bus8.rx_data, bus16.rx_data, bus16.busy);
    end
    rst_n = 1'b1;
    tick();
    last_rx8 = '0;
  endtask

  task automatic test_write();
    sel16 = 1'b0;
    exp_rx_q.push_back(18'h0A5);
    frame(1'b0, 18'h0A5, 10, 10);
    n_checks++;
    if (get_busy() !== 1'b1) begin n_fail++; $display("FAIL write_busy: got %b want 1", get_busy()); end
    end_frame();
    n_checks++;
    if (obs_nvalid != 1 || obs_nerr != 0 || obs_miso_hi != 0 || get_busy() !== 1'b0) begin
      n_fail++; $display("FAIL write_frame: got valid=%0d err=%0d miso_hi=%0d busy=%b want 1 0 0 0", obs_nvalid, obs_nerr, obs_miso_hi, get_busy());
    end
    last_rx8 = 18'h0A5;
  endtask

  task automatic test_read_addr();
    exp_rx_q.push_back(18'h233);
    frame(1'b1, 18'h233, 10, 10);
    end_frame();
    n_checks++;
    if (obs_miso_hi != 0 || obs_nerr != 0) begin n_fail++; $display("FAIL read_addr_state: got miso_hi=%0d err=%0d want 0 0", obs_miso_hi, obs_nerr); end
    exp_rx_q.push_back(18'h155);
    frame(1'b0, 18'h155, 10, 10);
    end_frame();
    n_checks++;
    if (obs_miso_hi != 0) begin n_fail++; $display("FAIL write_after_addr: got miso_hi=%0d want 0", obs_miso_hi); end
    last_rx8 = 18'h155;
  endtask

  task automatic test_read_data();
    exp_rx_q.push_back(18'h300);
    frame(1'b1, 18'h300, 10, 10);
    tx_stream(8, 16'h00C3);
    end_frame();
    n_checks++;
    if (obs_nerr != 0) begin n_fail++; $display("FAIL read_data_err: got %0d want 0", obs_nerr); end
    exp_rx_q.push_back(18'h0AA);
    frame(1'b1, 18'h0AA, 10, 10);
    end_frame();
    n_checks++;
    if (obs_miso_hi != 0) begin n_fail++; $display("FAIL rd_pend_clear: got miso_hi=%0d want 0", obs_miso_hi); end
    last_rx8 = 18'h0AA;
  endtask

  task automatic test_abort();
    frame(1'b0, 18'h2F0, 10, 5);
    drv(1'b1, 1'b0);
    tick();
    n_checks++;
    if (get_ferr() !== 1'b1 || get_rxv() !== 1'b0 || get_rx() !== last_rx8 || get_miso() !== 1'b0) begin
      n_fail++; $display("FAIL abort5: got err=%b valid=%b rx=%h miso=%b want 1 0 %h 0", get_ferr(), get_rxv(), get_rx(), get_miso(), last_rx8);
    end
    tick();
    n_checks++;
    if (get_ferr() !== 1'b0 || get_busy() !== 1'b0) begin
      n_fail++; $display("FAIL abort_after: got err=%b busy=%b want 0 0", get_ferr(), get_busy());
    end
    frame(1'b0, 18'h3FF, 10, 9);
    drv(1'b1, 1'b0);
    tick(); tick();
    n_checks++;
    if (obs_nerr != 1 || obs_nvalid != 0 || get_rx() !== last_rx8) begin
      n_fail++; $display("FAIL abort_last_bit: got err=%0d valid=%0d rx=%h want 1 0 %h", obs_nerr, obs_nvalid, get_rx(), last_rx8);
    end
    exp_rx_q.push_back(18'h1C7);
    frame(1'b0, 18'h1C7, 10, 10);
    end_frame();
    n_checks++;
    if (obs_nerr != 0 || obs_miso_hi != 0) begin n_fail++; $display("FAIL after_abort: got err=%0d miso_hi=%0d want 0 0", obs_nerr, obs_miso_hi); end
    last_rx8 = 18'h1C7;
  endtask

  task automatic test_abort_tx();
    logic [7:0] d;
    d = 8'hA5;
    exp_rx_q.push_back(18'h301);
    frame(1'b1, 18'h301, 10, 10);
    for (int i = 0; i < 3; i++) exp_bit_q.push_back(d[7-i]);
    drv_tx(1'b1, {8'h00, d});
    tick();
    drv_tx(1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      logic eb;
      if (i > 0) tick();
      eb = exp_bit_q.pop_front();
      n_checks++;
      if (get_miso() !== eb) begin n_fail++; $display("FAIL abort_tx_bit%0d: got %b want %b", 7 - i, get_miso(), eb); end
    end
    drv(1'b1, 1'b0);
    tick();
    n_checks++;
    if (get_ferr() !== 1'b1 || get_miso() !== 1'b0 || get_busy() !== 1'b0) begin
      n_fail++; $display("FAIL abort_tx: got err=%b miso=%b busy=%b want 1 0 0", get_ferr(), get_miso(), get_busy());
    end
    tick();
    exp_rx_q.push_back(18'h302);
    frame(1'b1, 18'h302, 10, 10);
    tx_stream(8, 16'h0069);
    end_frame();
    last_rx8 = 18'h302;
  endtask

  task automatic test_reset_tx();
    exp_rx_q.push_back(18'h011);
    frame(1'b1, 18'h011, 10, 10);
    end_frame();
    exp_rx_q.push_back(18'h312);
    frame(1'b1, 18'h312, 10, 10);
    drv_tx(1'b1, 16'h00C3);
    tick();
    drv_tx(1'b0, 16'h0000);
    tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({get_miso(), get_rxv(), get_ferr(), get_busy()} !== 4'b0000 || get_rx() !== 18'h0) begin
      n_fail++; $display("FAIL reset_in_tx: got ctrl=%b rx=%h want 0000 0", {get_miso(), get_rxv(), get_ferr(), get_busy()}, get_rx());
    end
    rst_n = 1'b1;
    drv(1'b1, 1'b0);
    tick(); tick();
    n_checks++;
    if (obs_nerr != 0) begin n_fail++; $display("FAIL reset_no_err: got %0d want 0", obs_nerr); end
    exp_rx_q.push_back(18'h044);
    frame(1'b1, 18'h044, 10, 10);
    end_frame();
    n_checks++;
    if (obs_miso_hi != 0) begin n_fail++; $display("FAIL reset_rd_pend: got miso_hi=%0d want 0", obs_miso_hi); end
  endtask

  task automatic test_dw16();
    sel16 = 1'b1;
    exp_rx_q.push_back(18'h21234);
    frame(1'b1, 18'h21234, 18, 18);
    end_frame();
    n_checks++;
    if (obs_miso_hi != 0) begin n_fail++; $display("FAIL dw16_addr: got miso_hi=%0d want 0", obs_miso_hi); end
    exp_rx_q.push_back(18'h30000);
    frame(1'b1, 18'h30000, 18, 18);
    tx_stream(16, 16'hA5F0);
    end_frame();
    n_checks++;
    if (obs_nerr != 0 || get_busy() !== 1'b0) begin
      n_fail++; $display("FAIL dw16_end: got err=%0d busy=%b want 0 0", obs_nerr, get_busy());
    end
    sel16 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus8.SS_n = 1'b1;  bus8.MOSI = 1'b0;  bus8.tx_valid = 1'b0;  bus8.tx_data = '0;
    bus16.SS_n = 1'b1; bus16.MOSI = 1'b0; bus16.tx_valid = 1'b0; bus16.tx_data = '0;
    clear_obs();
    test_reset();
    test_write();
    test_read_addr();
    test_read_data();
    test_abort();
    test_abort_tx();
    test_reset_tx();
    test_dw16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_slave_gen.md
Name: spi_slave_gen

Overview:
Parametrised SPI slave front-end for the memory-mapped wrapper. It is clocked directly by the SPI clock and samples MOSI on every rising clk while SS_n is low. It deserialises a 1-bit read/write selector plus a (DATA_W+2)-bit word (2-bit command + payload) and emits it to the memory side as a single-cycle rx_valid strobe. It returns read data on MISO after a tx_valid handshake, and flags truncated frames with frame_err.

Parameters:
DATA_W, 8, payload width; rx_data width RX_W = DATA_W+2, tx_data width DATA_W (RX_W is a derived localparam).
CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > RX_W.

Ports:
clk  in  1  SPI clock; all logic on rising edge.
rst_n  in  1  reset.
SS_n  in  1  slave select, active-low.
MOSI  in  1  serial data from master, MSB first.
MISO  out  1  serial data to master, registered.
rx_data  out  RX_W  received word {cmd[1:0], payload}.
rx_valid  out  1  one-cycle strobe; rx_data valid.
tx_data  in  DATA_W  read data from memory.
tx_valid  in  1  tx_data valid; sampled only in TX_WAIT.
busy  out  1  high when state != IDLE.
frame_err  out  1  one-cycle strobe; frame aborted by SS_n rising.

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. In reset: state=IDLE, MISO=0, rx_data=0, rx_valid=0, frame_err=0, busy=0, counter=0, rd_pend=0. Reset mid-frame abandons the frame without a frame_err pulse.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX, DONE.
- IDLE: SS_n=0 sampled -> CHK_CMD. No MOSI bit is captured in this cycle.
- CHK_CMD: MOSI sampled as the rw bit.
  - rw=0 -> WRITE.
  - rw=1 and rd_pend=0 -> READ_ADD.
  - rw=1 and rd_pend=1 -> READ_DATA.
- WRITE, READ_ADD, READ_DATA: shift MOSI into a shift register, MSB first, one bit per edge. counter runs 0..RX_W-1.
  - On the edge that captures bit RX_W-1: rx_data <= full word, rx_valid=1 for exactly the next cycle.
  - Next state after the last bit: WRITE -> DONE; READ_ADD -> DONE with rd_pend<=1; READ_DATA -> TX_WAIT.
  - rx_data holds its value until the next completed word. It is not cleared in IDLE.
- Latency: with SS_n first sampled low at edge 0, the rw bit is sampled at edge 1, data bits at edges 2..RX_W+1, and rx_valid is high during the cycle after edge RX_W+1.
- TX_WAIT: MISO=0.
  - On the first edge with tx_valid=1: latch tx_data, MISO <= tx_data[DATA_W-1], -> TX with counter=1.
  - There is no timeout; the state waits indefinitely while SS_n=0.
- TX: on each edge, MISO <= next lower bit of the latched data.
  - After bit 0 has been driven for one cycle: MISO<=0, rd_pend<=0, -> DONE.
  - Each bit is held for exactly one clk cycle.
  - tx_valid is ignored outside TX_WAIT.
- DONE: extra MOSI bits are ignored and MISO=0. SS_n=1 -> IDLE; no error in this case.
- Abort: SS_n=1 sampled in CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT or TX -> IDLE, frame_err=1 for one cycle, no rx_valid, MISO<=0.
  - rd_pend is unchanged on abort, so an aborted read-data frame is retried with the next rw=1 frame.
  - A bit is only captured while SS_n=0. If SS_n rises on the edge that would capture the last bit, that is an abort.
- Transition back to IDLE always resets counter to 0. Back-to-back frames need SS_n high for at least one sampled edge.
- MISO is 0 in every state except TX.

Test Plan:
1. DATA_W=8, write: SS_n low, rw=0, bits 00_1010_0101 -> rx_data=10'h0A5, rx_valid high exactly one cycle after the 10th data edge; MISO=0 throughout; no frame_err.
2. Read address: rw=1, bits 10_0011_0011 -> rx_data=10'h233, rx_valid pulse, rd_pend=1. A second write frame afterwards still enters WRITE.
3. Read data: with rd_pend=1, rw=1, bits 11_0000_0000 -> rx_valid pulse with rx_data=10'h300. Assert tx_valid with tx_data=8'hC3 three cycles later -> MISO = 1,1,0,0,0,0,1,1 on consecutive cycles, then 0; rd_pend=0; the next rw=1 frame goes to READ_ADD.
4. Abort: raise SS_n after 5 data bits of a write -> frame_err one-cycle pulse, rx_valid stays 0, rx_data unchanged, busy=0 next cycle. The next full frame completes normally.
5. Abort in TX after 3 MISO bits -> frame_err pulse, MISO=0, rd_pend stays 1. The retry read-data frame re-enters READ_DATA and outputs all 8 bits.
6. rst_n low during TX -> all outputs 0 next cycle with no frame_err. Repeat scenario 3 with DATA_W=16 and tx_data=16'hA5F0 -> 18-bit rx_data and a 16-bit MISO sequence, MSB first.
